// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and op-code width.
// Build option ALU_MUL_EN (see alu_seq) decides whether OP_MUL is implemented.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle, keeping the low WIDTH bits.
// done pulses on the last iteration; product is valid in that same cycle.
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] addend;
  logic             last_iter;

  assign addend    = b_q[0] ? a_q : '0;
  assign last_iter = busy_q && (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q + addend;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      if (last_iter) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + SHW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The final partial product is folded in combinationally so the result
  // is ready on the same edge that ends the iteration.
  assign busy    = busy_q;
  assign done    = last_iter;
  assign product = acc_q + addend;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags. Define ALU_MUL_EN to build the
// iterative multiplier and MUL_BUSY state; otherwise OP_MUL reports Illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALUControl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    Result,
  output logic                Zero,
  output logic                Negative,
  output logic                Carry,
  output logic                Overflow,
  output logic                Illegal
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic             accept;
  logic             consume;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid_q && out_ready;
  assign sum_w   = {1'b0, A} + {1'b0, B};
  assign diff_w  = {1'b0, A} - {1'b0, B};
  assign shamt   = B[SHW-1:0];

  // SUB carry is "no borrow", i.e. the inverted borrow out of the extended subtract.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = !diff_w[WIDTH];
        alu_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_res = WIDTH'(A < B);
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t state_q, state_d;
  logic       mul_start;
  logic       mul_busy;

  assign is_mul    = (ALUControl == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Returning on !mul_busy as well keeps the FSM from ever waiting on an idle multiplier.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done || !mul_busy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign in_ready    = !out_valid_q || out_ready;
`endif

  // A load in the same cycle as a consume wins, so out_valid stays high.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    if (consume) out_valid_d = 1'b0;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      neg_d       = alu_res[WIDTH-1];
      carry_d     = alu_carry;
      ovf_d       = alu_ovf;
      ill_d       = alu_ill;
    end
    if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_product;
      zero_d      = (mul_product == '0);
      neg_d       = mul_product[WIDTH-1];
      carry_d     = 1'b0;
      ovf_d       = 1'b0;
      ill_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor pops on each consume.
// MUL expectations follow the ALU_MUL_EN build option.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero, Negative, Carry, Overflow, Illegal;

  vec_t exp_q[$];
  vec_t dir_vecs[$];
  vec_t b2b_vecs[$];
  vec_t mul_v;
  int   mul_lat;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pop_cnt  = 0;
  int   cyc      = 0;
  int   last_pop_cyc = 0;
  bit   gap_check = 0;
  bit   gap_first = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .Negative   (Negative),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // flags packed as {Zero, Negative, Carry, Overflow, Illegal}
  function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic z, logic n, logic c, logic v, logic ill);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.res = res; t.flags = {z, n, c, v, ill};
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = v.op; A = v.a; B = v.b;
    exp_q.push_back(v);
    #1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL accept_timeout: actual=in_ready low required=accept within 200 cycles");
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    do begin
      @(negedge clk); #3; waited++;
    end while (!(exp_q.size() == 0 && !out_valid) && waited < 200);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops one expectation per consume, independent of the stimulus thread.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_output: actual Result=%h required=no output", Result);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("result#%0d", pop_cnt), Result, e.res);
          checkOutput($sformatf("flags#%0d", pop_cnt),
                      {27'd0, Zero, Negative, Carry, Overflow, Illegal}, {27'd0, e.flags});
          if (gap_check) begin
            if (!gap_first) checkOutput("b2b_gap", cyc - last_pop_cyc, 1);
            gap_first = 1'b0;
            last_pop_cyc = cyc;
          end
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    int low;
    int seen;
    int pops_before;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALUControl = '0; out_ready = 1'b1;

    dir_vecs.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1, 0, 0));
    dir_vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 1, 0));
    dir_vecs.push_back(mk(OP_SUB,  32'h3,        32'h5,        32'hFFFFFFFE, 0, 1, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SUB,  32'h5,        32'h3,        32'h2,        0, 0, 1, 0, 0));
    dir_vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 0, 1, 1, 0));
    dir_vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0, 0));
    dir_vecs.push_back(mk(OP_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_XOR,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SLT,  32'h80000000, 32'h1,        32'h1,        0, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SLTU, 32'h80000000, 32'h1,        32'h0,        1, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SLT,  32'h1,        32'h80000000, 32'h0,        1, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SLL,  32'h1,        32'h3F,       32'h80000000, 0, 1, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SRL,  32'h80000000, 32'h4,        32'h08000000, 0, 0, 0, 0, 0));
    dir_vecs.push_back(mk(OP_SRA,  32'h80000000, 32'h24,       32'hF8000000, 0, 1, 0, 0, 0));
    dir_vecs.push_back(mk(4'd12,   32'h1234,     32'h5678,     32'h0,        1, 0, 0, 0, 1));
    dir_vecs.push_back(mk(4'd15,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 0, 1));

    b2b_vecs.push_back(mk(OP_ADD, 32'h1,        32'h2,        32'h3,        0, 0, 0, 0, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'd10,       32'd20,       32'd30,       0, 0, 0, 0, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'h0000FFFF, 32'h1,        32'h00010000, 0, 0, 0, 0, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'h80000000, 32'h80000000, 32'h0,        1, 0, 1, 1, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'hFFFFFFFE, 32'h1,        32'hFFFFFFFF, 0, 1, 0, 0, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'd100,      32'hFFFFFFFF, 32'd99,       0, 0, 1, 0, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'h40000000, 32'h40000000, 32'h80000000, 0, 1, 0, 1, 0));
    b2b_vecs.push_back(mk(OP_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 0, 0));

`ifdef ALU_MUL_EN
    mul_v   = mk(OP_MUL, 32'd123456, 32'd789, 32'd97406784, 0, 0, 0, 0, 0);
    mul_lat = 32;
`else
    mul_v   = mk(OP_MUL, 32'd123456, 32'd789, 32'd0, 1, 0, 0, 0, 1);
    mul_lat = 0;
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", Result, 0);
    checkOutput("reset_flags", {Zero, Negative, Carry, Overflow, Illegal}, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    $display("[TB] directed single-cycle ops");
    applyStimulus(dir_vecs[0]);
    @(negedge clk); #1;
    checkOutput("latency1_out_valid", out_valid, 1);
    for (int i = 1; i < dir_vecs.size(); i++) applyStimulus(dir_vecs[i]);
    drain();

    $display("[TB] multiply latency");
    applyStimulus(mul_v);
    low = 0;
    while (low < 100) begin
      @(negedge clk); #1;
      if (in_ready) break;
      low++;
    end
    checkOutput("mul_in_ready_low_cycles", low, mul_lat);
    drain();

    $display("[TB] back-pressure hold");
    @(negedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(mul_v);
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(negedge clk); #1; seen++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput("hold_result", Result, mul_v.res);
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    drain();

`ifdef ALU_MUL_EN
    $display("[TB] reset during multiply");
    applyStimulus(mul_v);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("abort_out_valid_count", seen, 0);
    checkOutput("abort_in_ready", in_ready, 1);
`endif

    $display("[TB] back-to-back adds");
    pops_before = pop_cnt;
    gap_check = 1'b1;
    gap_first = 1'b1;
    for (int i = 0; i < b2b_vecs.size(); i++) applyStimulus(b2b_vecs[i]);
    drain();
    gap_check = 1'b0;
    checkOutput("b2b_result_count", pop_cnt - pops_before, 8);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
